// File: rtl/amp_readback_meter.sv
// Window peak-magnitude meter: scales the peak back to PS gain units (peak/DIV) and returns it over valid/ready.
// Optional build macro AMP_READBACK_CONTINUOUS_EN keeps accumulating during DIVIDE/HOLD and flags overwrites on overrun.
module amp_readback_meter #(
    parameter int SAMPLE_W = 12,
    parameter int GAIN_W   = 9,
    parameter int WIN_LEN  = 1024,
    parameter int DIV      = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [SAMPLE_W-1:0] sample_in,
    input  logic                       sample_valid,
    output logic [GAIN_W-1:0]          meas_gain,
    output logic [SAMPLE_W-1:0]        peak_raw,
    output logic                       meas_valid,
    input  logic                       meas_ready,
    output logic                       sat_flag,
    output logic                       overrun
);
    localparam int CW  = $clog2(WIN_LEN);
    localparam int RW  = $clog2(DIV + 1);
    localparam int TW  = RW + 1;
    localparam int DCW = $clog2(SAMPLE_W + 1);
    localparam int XW  = ((SAMPLE_W > GAIN_W) ? SAMPLE_W : GAIN_W) + 1;

    localparam logic [SAMPLE_W-1:0] MOST_NEG = {1'b1, {(SAMPLE_W-1){1'b0}}};
    localparam logic [SAMPLE_W-1:0] MAG_MAX  = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam logic [XW-1:0]       GMAX     = XW'({GAIN_W{1'b1}});

    typedef enum logic [1:0] {ACCUM, DIVIDE, HOLD} state_t;
    state_t state, state_n;

    logic [CW-1:0]       cnt;
    logic [SAMPLE_W-1:0] peak_acc, mag, cur_max;
    logic [SAMPLE_W-1:0] dvd;
    logic [RW-1:0]       rem;
    logic [DCW-1:0]      dcnt;
    logic [TW-1:0]       trial, diff;
    logic                trial_ok;
    logic [XW-1:0]       quot_x;
    logic                sat;
    logic                accum_en, win_done, start_div, div_last;

    // Most-negative code has no positive twin; saturate instead of wrapping to itself.
    always_comb begin
        mag = sample_in;
        if (sample_in == MOST_NEG)
            mag = MAG_MAX;
        else if (sample_in[SAMPLE_W-1])
            mag = ~sample_in + SAMPLE_W'(1);
    end

    assign cur_max = (mag > peak_acc) ? mag : peak_acc;

`ifdef AMP_READBACK_CONTINUOUS_EN
    assign accum_en = sample_valid;
`else
    assign accum_en = sample_valid && (state == ACCUM);
`endif

    assign win_done   = accum_en && (cnt == CW'(WIN_LEN - 1));
    assign start_div  = win_done && (state != DIVIDE);
    assign div_last   = (state == DIVIDE) && (dcnt == DCW'(SAMPLE_W));
    assign meas_valid = (state == HOLD);

    // Restoring divider: dvd shifts the dividend out and the quotient in.
    assign trial    = {rem, dvd[SAMPLE_W-1]};
    assign trial_ok = (trial >= TW'(DIV));
    assign diff     = trial - TW'(DIV);
    assign quot_x   = XW'(dvd);
    assign sat      = (quot_x > GMAX);

    always_comb begin
        state_n = state;
        case (state)
            ACCUM:  if (start_div) state_n = DIVIDE;
            DIVIDE: if (div_last) state_n = HOLD;
            HOLD: begin
                if (start_div)
                    state_n = DIVIDE;
                else if (meas_ready)
                    state_n = ACCUM;
            end
            default: state_n = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= ACCUM;
        else
            state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            peak_acc  <= '0;
            peak_raw  <= '0;
            meas_gain <= '0;
            sat_flag  <= 1'b0;
            dvd       <= '0;
            rem       <= '0;
            dcnt      <= '0;
        end else begin
            if (accum_en) begin
                if (win_done) begin
                    cnt      <= '0;
                    peak_acc <= '0;
                end else begin
                    cnt      <= cnt + CW'(1);
                    peak_acc <= cur_max;
                end
            end
            if (start_div) begin
                peak_raw <= cur_max;
                dvd      <= cur_max;
                rem      <= '0;
                dcnt     <= '0;
            end else if (state == DIVIDE && !div_last) begin
                rem  <= trial_ok ? diff[RW-1:0] : trial[RW-1:0];
                dvd  <= {dvd[SAMPLE_W-2:0], trial_ok};
                dcnt <= dcnt + DCW'(1);
            end
            if (div_last) begin
                meas_gain <= sat ? {GAIN_W{1'b1}} : quot_x[GAIN_W-1:0];
                sat_flag  <= sat;
            end
        end
    end

`ifdef AMP_READBACK_CONTINUOUS_EN
    // A result is lost if a window lands mid-divide, or on an unacknowledged HOLD.
    logic ovr;
    always_ff @(posedge clk) begin
        if (rst)
            ovr <= 1'b0;
        else if (win_done && (state == DIVIDE || (state == HOLD && !meas_ready)))
            ovr <= 1'b1;
    end
    assign overrun = ovr;
`else
    assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_amp_readback_meter.sv
// Directed + randomized bench for amp_readback_meter (WIN_LEN=8) with GAIN_W=9 and GAIN_W=8 instances.
module tb_amp_readback_meter;
    localparam int SW = 12;
    localparam int WL = 8;
    localparam int DV = 5;
    localparam int LAT = SW + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic signed [SW-1:0] sample_in = '0;
    logic sample_valid = 1'b0;
    logic meas_ready = 1'b0;

    logic [8:0]    gain9;
    logic [7:0]    gain8;
    logic [SW-1:0] peak9, peak8;
    logic          valid9, valid8, sat9, sat8, ovr9, ovr8;

    int n_checks = 0;
    int n_pass = 0;
    logic signed [SW-1:0] win [WL];

    amp_readback_meter #(.SAMPLE_W(SW), .GAIN_W(9), .WIN_LEN(WL), .DIV(DV)) dut (
        .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
        .meas_gain(gain9), .peak_raw(peak9), .meas_valid(valid9), .meas_ready(meas_ready),
        .sat_flag(sat9), .overrun(ovr9));

    amp_readback_meter #(.SAMPLE_W(SW), .GAIN_W(8), .WIN_LEN(WL), .DIV(DV)) dut8 (
        .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
        .meas_gain(gain8), .peak_raw(peak8), .meas_valid(valid8), .meas_ready(meas_ready),
        .sat_flag(sat8), .overrun(ovr8));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Reference: |x| clamped to the largest positive code, peak over the window.
    function automatic int mag_of(input logic signed [SW-1:0] s);
        int v;
        v = int'(s);
        if (v < 0) v = -v;
        if (v > 2**(SW-1) - 1) v = 2**(SW-1) - 1;
        return v;
    endfunction

    function automatic int model_peak();
        int p;
        p = 0;
        for (int i = 0; i < WL; i++)
            if (mag_of(win[i]) > p) p = mag_of(win[i]);
        return p;
    endfunction

    task automatic send_n(input int first, input int last, input bit gaps);
        for (int i = first; i <= last; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    sample_valid = 1'b0;
                    sample_in = SW'($urandom);
                    tick();
                end
            end
            sample_in = win[i];
            sample_valid = 1'b1;
            tick();
        end
        sample_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag);
        int n;
        n = 0;
        while (!valid9 && n < 40) begin
            tick();
            n++;
        end
        check({tag, ".latency"}, n, LAT);
        check({tag, ".valid8"}, valid8, 1);
    endtask

    task automatic check_outputs(input string tag);
        int p, q;
        p = model_peak();
        q = p / DV;
        check({tag, ".peak9"}, peak9, p);
        check({tag, ".gain9"}, gain9, (q > 511) ? 511 : q);
        check({tag, ".sat9"}, sat9, (q > 511) ? 1 : 0);
        check({tag, ".peak8"}, peak8, p);
        check({tag, ".gain8"}, gain8, (q > 255) ? 255 : q);
        check({tag, ".sat8"}, sat8, (q > 255) ? 1 : 0);
    endtask

    task automatic ack(input string tag);
        meas_ready = 1'b1;
        tick();
        meas_ready = 1'b0;
        check({tag, ".ack_drop"}, valid9, 0);
        check_outputs({tag, ".kept"});
    endtask

    task automatic count_valid(input int cycles, output int hits);
        hits = 0;
        repeat (cycles) begin
            tick();
            if (valid9 || valid8) hits++;
        end
    endtask

    initial begin
        int hits;

        repeat (3) tick();
        check("reset.valid", {valid9, valid8}, 0);
        check("reset.peak", {peak9, peak8}, 0);
        check("reset.gain", {gain9, gain8}, 0);
        check("reset.sat", {sat9, sat8}, 0);
        check("reset.overrun", {ovr9, ovr8}, 0);
        rst = 1'b0;
        tick();

        // Reference window with ready held high throughout.
        win = '{12'sd10, -12'sd300, 12'sd1000, 12'sd5, -12'sd7, 12'sd0, 12'sd999, 12'sd3};
        meas_ready = 1'b1;
        send_n(0, WL - 1, 1'b0);
        wait_result("basic");
        check_outputs("basic");
        check("basic.gain_const", gain9, 200);
        tick();
        meas_ready = 1'b0;
        check("basic.drop", valid9, 0);
        check_outputs("basic.kept");

        win = '{12'sd4, -12'sd2048, 12'sd100, 12'sd0, -12'sd1, 12'sd2047, 12'sd7, 12'sd9};
        send_n(0, WL - 1, 1'b1);
        wait_result("mostneg");
        check_outputs("mostneg");
        check("mostneg.peak_const", peak9, 2047);
        ack("mostneg");

        win = '{default: 12'sd0};
        send_n(0, WL - 1, 1'b0);
        wait_result("zero");
        check_outputs("zero");
        ack("zero");

        win = '{12'sd1, 12'sd2, -12'sd2000, 12'sd3, 12'sd4, 12'sd5, 12'sd6, 12'sd7};
        send_n(0, WL - 1, 1'b0);
        wait_result("clamp");
        check_outputs("clamp");
        check("clamp.gain8_const", gain8, 255);
        ack("clamp");

        // Outputs stable while ready is withheld; streamed samples must be dropped.
        win = '{12'sd50, -12'sd60, 12'sd70, 12'sd80, -12'sd90, 12'sd33, 12'sd44, 12'sd1};
        send_n(0, WL - 1, 1'b0);
        wait_result("hold");
        for (int c = 0; c < 50; c++) begin
            sample_in = (c % 5 == 0) ? -12'sd2048 : SW'($urandom);
            sample_valid = 1'b1;
            tick();
            check("hold.valid", valid9, 1);
            check_outputs("hold.stable");
        end
        sample_valid = 1'b0;
        ack("hold");
        win = '{12'sd11, -12'sd22, 12'sd33, 12'sd44, -12'sd55, 12'sd66, 12'sd77, -12'sd88};
        send_n(0, WL - 2, 1'b0);
        count_valid(20, hits);
        check("fresh.no_early", hits, 0);
        send_n(WL - 1, WL - 1, 1'b0);
        wait_result("fresh");
        check_outputs("fresh");
        ack("fresh");

        // Reset during DIVIDE discards the result.
        win = '{12'sd1500, 12'sd2, 12'sd3, 12'sd4, 12'sd5, 12'sd6, 12'sd7, 12'sd8};
        send_n(0, WL - 1, 1'b0);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstdiv.peak", peak9, 0);
        check("rstdiv.gain", gain9, 0);
        count_valid(30, hits);
        check("rstdiv.no_valid", hits, 0);
        win = '{-12'sd123, 12'sd456, 12'sd7, 12'sd8, 12'sd9, 12'sd10, 12'sd11, 12'sd12};
        send_n(0, WL - 1, 1'b1);
        wait_result("after_rstdiv");
        check_outputs("after_rstdiv");
        ack("after_rstdiv");

        // Reset mid-window discards the partial peak.
        win = '{default: 12'sd1900};
        send_n(0, 4, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        win = '{12'sd21, 12'sd22, 12'sd23, -12'sd24, 12'sd25, 12'sd26, 12'sd27, 12'sd28};
        send_n(0, WL - 1, 1'b0);
        wait_result("rstacc");
        check_outputs("rstacc");
        ack("rstacc");

        // Final sample coincident with reset: reset wins.
        win = '{default: 12'sd1700};
        send_n(0, WL - 2, 1'b0);
        sample_in = win[WL - 1];
        sample_valid = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sample_valid = 1'b0;
        count_valid(30, hits);
        check("rstfinal.no_valid", hits, 0);
        check("rstfinal.peak", peak9, 0);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < WL; i++) win[i] = SW'($urandom);
            send_n(0, WL - 1, 1'b1);
            wait_result("rand");
            check_outputs("rand");
            repeat ($urandom_range(0, 4)) tick();
            ack("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
